dmem_responder: RTL and testbench

Responder side of the MEM-stage data-memory request interface. The pipeline's MEM stage issues load/store requests and holds itself stalled on `busy`. This block accepts one request at a time, waits a programmable number of cycles, commits the write or fetches the read data, and returns a single-cycle response. It is byte-addressed and little-endian, and it performs byte/half/word lane selection plus sign or zero extension. It replaces the zero-latency data memory so that hazard logic can be exercised against a multi-cycle memory.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_lane_align.sv | 36 +++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    typedef enum logic [1:0] {BYTE, HALF, WORD, ILLEGAL} dmem_size_t;

    localparam int unsigned NBYTES_BYTE = 1;
    localparam int unsigned NBYTES_HALF = 2;
    localparam int unsigned NBYTES_WORD = 4;

    // Exactly one size bit must be set; anything else is illegal.
    function automatic dmem_size_t decode_size(input logic one_byte,
                                               input logic two_byte,
                                               input logic four_bytes);
        dmem_size_t size;
        case ({four_bytes, two_byte, one_byte})
            3'b001:  size = BYTE;
            3'b010:  size = HALF;
            3'b100:  size = WORD;
            default: size = ILLEGAL;
        endcase
        return size;
    endfunction

    function automatic logic [3:0] byte_enables(input dmem_size_t size,
                                                input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'(((1 << NBYTES_BYTE) - 1) << offset);
            HALF:    be = 4'(((1 << NBYTES_HALF) - 1) << offset);
            WORD:    be = 4'(((1 << NBYTES_WORD) - 1) << offset);
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load lane selection with sign/zero extension, plus the alignment check
// shared by loads and stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  dmem_size_t  size,
    input  logic [1:0]  offset,
    input  logic        zero_ext,
    input  logic [31:0] raw,
    output logic [31:0] data_c,
    output logic        misaligned_c
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b       = raw[{offset, 3'b000} +: 8];
        lane_h       = raw[{offset[1], 4'b0000} +: 16];
        data_c       = '0;
        misaligned_c = 1'b0;
        case (size)
            BYTE: data_c = zero_ext ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            HALF: begin
                misaligned_c = offset[0];
                data_c       = zero_ext ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            WORD: begin
                misaligned_c = (offset != 2'b00);
                data_c       = raw;
            end
            default: data_c = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle byte-addressed little-endian data memory answering one
// MEM-stage load/store at a time after a fixed LATENCY.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 12,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [DEPTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic             one_byte,
    input  logic             two_byte,
    input  logic             four_bytes,
    input  logic             unsigned_load,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             busy
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned NUM_BYTES = 2 ** DEPTH;

    logic [7:0] mem [NUM_BYTES];

    dmem_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             commit;

    logic             held_write;
    logic [DEPTH-1:0] held_addr;
    logic [WIDTH-1:0] held_wdata;
    dmem_size_t       held_size;
    logic             held_unsigned;

    logic             cur_write;
    logic [DEPTH-1:0] cur_addr;
    logic [WIDTH-1:0] cur_wdata;
    dmem_size_t       cur_size;
    logic             cur_unsigned;

    logic [31:0]      raw_word;
    logic [31:0]      load_data;
    logic [31:0]      store_lanes;
    logic [3:0]       be;
    logic             misaligned;
    logic             access_err;

    // With LATENCY=1 the commit edge is the accept edge, so operands come
    // straight from the inputs while idle.
    always_comb begin
        cur_write    = (state == IDLE) ? req_write     : held_write;
        cur_addr     = (state == IDLE) ? req_addr      : held_addr;
        cur_wdata    = (state == IDLE) ? req_wdata     : held_wdata;
        cur_unsigned = (state == IDLE) ? unsigned_load : held_unsigned;
        cur_size     = (state == IDLE) ? decode_size(one_byte, two_byte, four_bytes)
                                       : held_size;
    end

    always_comb begin
        raw_word = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            raw_word[8*i +: 8] = mem[{cur_addr[DEPTH-1:2], 2'(i)}];
        end
    end

    dmem_lane_align u_lane_align (
        .size         (cur_size),
        .offset       (cur_addr[1:0]),
        .zero_ext     (cur_unsigned),
        .raw          (raw_word),
        .data_c       (load_data),
        .misaligned_c (misaligned)
    );

    assign access_err  = (cur_size == ILLEGAL) || misaligned;
    assign be          = byte_enables(cur_size, cur_addr[1:0]);
    assign store_lanes = 32'(cur_wdata) << {cur_addr[1:0], 3'b000};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_next = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            held_write    <= 1'b0;
            held_addr     <= '0;
            held_wdata    <= '0;
            held_size     <= ILLEGAL;
            held_unsigned <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            req_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            rsp_valid <= (state_next == RESP);
            if (state == IDLE && req_valid) begin
                held_write    <= req_write;
                held_addr     <= req_addr;
                held_wdata    <= req_wdata;
                held_size     <= decode_size(one_byte, two_byte, four_bytes);
                held_unsigned <= unsigned_load;
            end
            if (commit) begin
                rsp_err   <= access_err;
                rsp_rdata <= (access_err || cur_write) ? '0 : WIDTH'(load_data);
            end
        end
    end

    // Storage: cleared on reset, written only on an error-free store commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                mem[DEPTH'(i)] <= '0;
            end
        end else if (commit && cur_write && !access_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[{cur_addr[DEPTH-1:2], 2'(i)}] <= store_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY 2, 1 and 5 builds against a byte-array
// reference model, with directed corner cases and random traffic.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst, req_valid, req_write, one_byte, two_byte, four_bytes, unsigned_load;
    logic [2:0][11:0]  req_addr;
    logic [2:0][31:0]  req_wdata;
    wire  [2:0]        req_ready, rsp_valid, rsp_err, busy;
    wire  [2:0][31:0]  rsp_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] mref [3][4096];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .WIDTH   (32),
            .DEPTH   (12),
            .LATENCY ((g == 0) ? 2 : (g == 1) ? 1 : 5)
        ) u_dut (
            .clk           (clk),
            .rst           (rst[g]),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_write     (req_write[g]),
            .req_addr      (req_addr[g]),
            .req_wdata     (req_wdata[g]),
            .one_byte      (one_byte[g]),
            .two_byte      (two_byte[g]),
            .four_bytes    (four_bytes[g]),
            .unsigned_load (unsigned_load[g]),
            .rsp_valid     (rsp_valid[g]),
            .rsp_rdata     (rsp_rdata[g]),
            .rsp_err       (rsp_err[g]),
            .busy          (busy[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model(input int k);
        for (int i = 0; i < 4096; i++) mref[k][i] = 8'h00;
    endtask

    // Reference: n-byte little-endian access with alignment and size rules.
    task automatic model_access(input int k, input logic wr, input logic [11:0] a,
                                input logic [31:0] wd, input logic [2:0] sz, input logic uns,
                                output logic [31:0] ed, output logic ee);
        int n;
        logic [31:0] v;
        case (sz)
            3'b001:  n = 1;
            3'b010:  n = 2;
            3'b100:  n = 4;
            default: n = 0;
        endcase
        if (n == 0) ee = 1'b1;
        else        ee = ((int'(a) % n) != 0);
        ed = 32'd0;
        if (!ee) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mref[k][12'(int'(a) + i)] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mref[k][12'(int'(a) + i)]) << (8 * i));
                if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                ed = v;
            end
        end
    endtask

    task automatic drive_req(input int k, input logic v, input logic wr, input logic [11:0] a,
                             input logic [31:0] wd, input logic [2:0] sz, input logic uns);
        req_valid[k]     = v;
        req_write[k]     = wr;
        req_addr[k]      = a;
        req_wdata[k]     = wd;
        one_byte[k]      = sz[0];
        two_byte[k]      = sz[1];
        four_bytes[k]    = sz[2];
        unsigned_load[k] = uns;
    endtask

    // Called and returns at a negedge; checks timing, handshake and result.
    task automatic do_req(input int k, input logic wr, input logic [11:0] a,
                          input logic [31:0] wd, input logic [2:0] sz, input logic uns,
                          input string tag);
        logic [31:0] ed;
        logic        ee;
        int          lat;
        lat = lat_of(k);
        model_access(k, wr, a, wd, sz, uns, ed, ee);
        check_eq($sformatf("%s k%0d ready_at_issue", tag, k), 32'(req_ready[k]), 32'd1);
        drive_req(k, 1'b1, wr, a, wd, sz, uns);
        @(posedge clk);
        #1;
        drive_req(k, 1'b1, 1'($urandom), 12'($urandom), $urandom, 3'($urandom), 1'($urandom));
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check_eq($sformatf("%s k%0d busy c%0d", tag, k, c), 32'(busy[k]), 32'd1);
            check_eq($sformatf("%s k%0d ready c%0d", tag, k, c), 32'(req_ready[k]), 32'd0);
            check_eq($sformatf("%s k%0d rsp_valid c%0d", tag, k, c), 32'(rsp_valid[k]),
                     (c == lat) ? 32'd1 : 32'd0);
            if (c == lat) begin
                check_eq($sformatf("%s k%0d rdata", tag, k), rsp_rdata[k], ed);
                check_eq($sformatf("%s k%0d err", tag, k), 32'(rsp_err[k]), 32'(ee));
                req_valid[k] = 1'b0;
            end
        end
        @(negedge clk);
        check_eq($sformatf("%s k%0d rsp_valid_after", tag, k), 32'(rsp_valid[k]), 32'd0);
        check_eq($sformatf("%s k%0d busy_after", tag, k), 32'(busy[k]), 32'd0);
    endtask

    function automatic logic [2:0] rand_size();
        int r;
        r = $urandom_range(0, 7);
        if (r < 2) return 3'b001;
        if (r < 4) return 3'b010;
        if (r < 6) return 3'b100;
        return 3'($urandom);
    endfunction

    initial begin
        rst = 3'b111;
        for (int k = 0; k < 3; k++) begin
            drive_req(k, 1'b0, 1'b0, 12'h000, 32'h0, 3'b000, 1'b0);
            clear_model(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("reset k%0d req_ready", k), 32'(req_ready[k]), 32'd1);
            check_eq($sformatf("reset k%0d rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
            check_eq($sformatf("reset k%0d rsp_rdata", k), rsp_rdata[k], 32'd0);
            check_eq($sformatf("reset k%0d rsp_err", k), 32'(rsp_err[k]), 32'd0);
            check_eq($sformatf("reset k%0d busy", k), 32'(busy[k]), 32'd0);
        end
        rst = 3'b000;

        do_req(0, 1'b1, 12'h010, 32'hDEADBEEF, 3'b100, 1'b0, "sw");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b100, 1'b0, "lw");
        do_req(0, 1'b0, 12'h013, 32'h0, 3'b001, 1'b0, "lb");
        do_req(0, 1'b0, 12'h013, 32'h0, 3'b001, 1'b1, "lbu");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b010, 1'b0, "lh");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b010, 1'b1, "lhu");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b100, 1'b1, "lw_uns");
        do_req(0, 1'b1, 12'h011, 32'hABCDEF55, 3'b001, 1'b0, "sb");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b100, 1'b0, "lw_after_sb");
        do_req(0, 1'b0, 12'h012, 32'h0, 3'b100, 1'b0, "lw_misaligned");
        do_req(0, 1'b1, 12'h011, 32'h00001234, 3'b010, 1'b0, "sh_misaligned");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b100, 1'b0, "lw_unchanged");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b000, 1'b0, "size000");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b011, 1'b0, "size011");
        do_req(0, 1'b1, 12'h010, 32'h0, 3'b111, 1'b0, "sw_size111");
        do_req(0, 1'b0, 12'h010, 32'h0, 3'b100, 1'b0, "lw_after_illegal");

        // Store aborted by a reset in WAIT; reset also clears storage.
        drive_req(0, 1'b1, 1'b1, 12'h020, 32'h12345678, 3'b100, 1'b0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        clear_model(0);
        @(negedge clk);
        rst[0] = 1'b0;
        check_eq("rst_abort busy", 32'(busy[0]), 32'd0);
        check_eq("rst_abort ready", 32'(req_ready[0]), 32'd1);
        check_eq("rst_abort rsp_valid", 32'(rsp_valid[0]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("rst_abort quiet c%0d", c), 32'(rsp_valid[0]), 32'd0);
        end
        do_req(0, 1'b0, 12'h020, 32'h0, 3'b100, 1'b0, "lw_after_rst");

        for (int k = 1; k < 3; k++) begin
            do_req(k, 1'b1, 12'h010, 32'hDEADBEEF, 3'b100, 1'b0, "sw");
            do_req(k, 1'b0, 12'h013, 32'h0, 3'b001, 1'b0, "lb");
            do_req(k, 1'b0, 12'h012, 32'h0, 3'b010, 1'b1, "lhu");
            do_req(k, 1'b1, 12'hFFC, 32'hCAFEF00D, 3'b100, 1'b0, "sw_top");
            do_req(k, 1'b0, 12'hFFE, 32'h0, 3'b010, 1'b0, "lh_top");
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 60; i++) begin
                do_req(k, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom,
                       rand_size(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
